// File: rtl/module_spi_txn_ctrl.sv
// SPI transaction sequencer: walks the byte counter over the TX/RX bank, drives the shifter and owns chip select.
// Optional SPI_CTRL_CS_GUARD_EN adds one guard cycle of chip select before the first byte and after the last.
module module_spi_txn_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 send_i,
  input  logic                 all_ones_i,
  input  logic                 all_zeros_i,
  input  logic [CNT_WIDTH-1:0] n_tx_end_i,
  input  logic                 spi_done_i,
  output logic                 spi_start_o,
  output logic [1:0]           mux_sel_o,
  output logic [CNT_WIDTH-1:0] addr_o,
  output logic                 wr_en_o,
  output logic                 cs_n_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] n_tx_o
);

  // The byte width only sizes the surrounding datapath; reject a nonsensical value at elaboration.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("DATA_WIDTH must be at least 1");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_STORE = 3'd5,
    ST_HOLD  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  state_t               state_r;
  logic [CNT_WIDTH-1:0] end_r;

  function automatic logic [1:0] fill_sel(input logic ones, input logic zeros);
    logic [1:0] sel;
    if (ones) begin
      sel = 2'b01;
    end else if (zeros) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Sequencer state, latched configuration and all registered Moore outputs; addr_o doubles as the byte counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      end_r       <= CNT_ZERO;
      spi_start_o <= 1'b0;
      mux_sel_o   <= 2'b00;
      addr_o      <= CNT_ZERO;
      wr_en_o     <= 1'b0;
      cs_n_o      <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      n_tx_o      <= CNT_ZERO;
    end else begin
      spi_start_o <= 1'b0;
      wr_en_o     <= 1'b0;
      done_o      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (send_i) begin
            end_r     <= n_tx_end_i;
            mux_sel_o <= fill_sel(all_ones_i, all_zeros_i);
            addr_o    <= CNT_ZERO;
            n_tx_o    <= CNT_ZERO;
            cs_n_o    <= 1'b0;
            busy_o    <= 1'b1;
`ifdef SPI_CTRL_CS_GUARD_EN
            state_r   <= ST_SETUP;
`else
            state_r   <= ST_LOAD;
`endif
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          spi_start_o <= 1'b1;
          state_r     <= ST_START;
        end
        ST_START: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spi_done_i) begin
            wr_en_o <= 1'b1;
            state_r <= ST_STORE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_STORE: begin
          n_tx_o <= n_tx_o + CNT_ONE;
          // The counter stops at the latched end index, so a full bank never wraps the address.
          if (addr_o == end_r) begin
`ifdef SPI_CTRL_CS_GUARD_EN
            state_r <= ST_HOLD;
`else
            done_o  <= 1'b1;
            cs_n_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_r <= ST_DONE;
`endif
          end else begin
            addr_o  <= addr_o + CNT_ONE;
            state_r <= ST_LOAD;
          end
        end
        ST_HOLD: begin
          done_o  <= 1'b1;
          cs_n_o  <= 1'b1;
          busy_o  <= 1'b0;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          cs_n_o  <= 1'b1;
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_spi_txn_ctrl.sv
// Directed bench for module_spi_txn_ctrl: cycle vector table plus multi-cycle transaction sequences.
// Expected timing follows SPI_CTRL_CS_GUARD_EN when the bench is built with it.
module tb_module_spi_txn_ctrl;

`ifdef SPI_CTRL_CS_GUARD_EN
  localparam int GUARD = 1;
`else
  localparam int GUARD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       send, all_ones, all_zeros, spi_done;
  logic [9:0] n_tx_end;
  logic       spi_start, wr_en, cs_n, busy, done;
  logic [1:0] mux_sel;
  logic [9:0] addr, n_tx;
  logic       spi_start3, wr_en3, cs_n3, busy3, done3;
  logic [1:0] mux_sel3;
  logic [2:0] addr3, n_tx3;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  module_spi_txn_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(10)) dut (
    .clk_i(clk), .rst_i(rst), .send_i(send), .all_ones_i(all_ones), .all_zeros_i(all_zeros),
    .n_tx_end_i(n_tx_end), .spi_done_i(spi_done), .spi_start_o(spi_start), .mux_sel_o(mux_sel),
    .addr_o(addr), .wr_en_o(wr_en), .cs_n_o(cs_n), .busy_o(busy), .done_o(done), .n_tx_o(n_tx)
  );

  module_spi_txn_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .send_i(send), .all_ones_i(all_ones), .all_zeros_i(all_zeros),
    .n_tx_end_i(n_tx_end[2:0]), .spi_done_i(spi_done), .spi_start_o(spi_start3), .mux_sel_o(mux_sel3),
    .addr_o(addr3), .wr_en_o(wr_en3), .cs_n_o(cs_n3), .busy_o(busy3), .done_o(done3), .n_tx_o(n_tx3)
  );

  typedef struct {
    logic       send, ones, zeros;
    logic [9:0] endv;
    logic       sdone;
    logic       start;
    logic [1:0] sel;
    logic [9:0] addr;
    logic       wr, csn, busy, done;
    logic [9:0] ntx;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic s, input logic o, input logic z, input logic [9:0] e,
                              input logic d, input logic st, input logic [1:0] sl, input logic [9:0] a,
                              input logic w, input logic c, input logic b, input logic dn,
                              input logic [9:0] n);
    vec_t v;
    v.send = s; v.ones = o; v.zeros = z; v.endv = e; v.sdone = d;
    v.start = st; v.sel = sl; v.addr = a; v.wr = w; v.csn = c; v.busy = b; v.done = dn; v.ntx = n;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic st, input logic [1:0] sl, input logic [9:0] a,
                          input logic w, input logic c, input logic b, input logic dn,
                          input logic [9:0] n);
    chk({tag, ".start"}, 32'(spi_start), 32'(st));
    chk({tag, ".sel"},   32'(mux_sel),   32'(sl));
    chk({tag, ".addr"},  32'(addr),      32'(a));
    chk({tag, ".wr"},    32'(wr_en),     32'(w));
    chk({tag, ".cs_n"},  32'(cs_n),      32'(c));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".done"},  32'(done),      32'(dn));
    chk({tag, ".n_tx"},  32'(n_tx),      32'(n));
  endtask

  // One send pulse, shifter replies dly cycles after each start; checks counts, addresses and timing.
  task automatic run_txn(input string tag, input logic [9:0] endv, input logic ones, input logic zeros,
                         input int dly, input bit chk3);
    int cyc, pend, starts, dones, first_start, last_wr, done_cyc, cs_bad, sel_bad, nwr, nbad;
    int starts3, dones3, nwr3, bad3, budget, nbytes;
    logic [1:0] expsel;
    expsel = ones ? 2'b01 : (zeros ? 2'b10 : 2'b00);
    nbytes = int'(endv) + 1;
    budget = nbytes * (dly + 8) + 20;
    starts = 0; dones = 0; first_start = -1; last_wr = -1; done_cyc = -1;
    cs_bad = 0; sel_bad = 0; nwr = 0; nbad = 0; starts3 = 0; dones3 = 0; nwr3 = 0; bad3 = 0;
    send = 1'b1; n_tx_end = endv; all_ones = ones; all_zeros = zeros; spi_done = 1'b0;
    @(posedge clk); #1;
    send = 1'b0;
    cyc = 1; pend = -1;
    while (cyc <= budget && dones == 0) begin
      if (spi_start) begin
        starts++;
        if (first_start < 0) first_start = cyc;
        pend = cyc + dly;
      end
      if (wr_en) begin
        if (addr !== 10'(nwr) || n_tx !== 10'(nwr)) nbad++;
        nwr++;
        last_wr = cyc;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        if (cs_n !== 1'b1 || busy !== 1'b0) cs_bad++;
      end else if (cs_n !== 1'b0 || busy !== 1'b1) begin
        cs_bad++;
      end
      if (mux_sel !== expsel) sel_bad++;
      if (chk3) begin
        if (spi_start3) starts3++;
        if (wr_en3) begin
          if (addr3 !== 3'(nwr3) || n_tx3 !== 3'(nwr3)) bad3++;
          nwr3++;
        end
        if (done3) dones3++;
        if (mux_sel3 !== expsel || cs_n3 !== done3 || busy3 === done3) bad3++;
      end
      spi_done = (cyc == pend);
      @(posedge clk); #1;
      cyc++;
    end
    spi_done = 1'b0;
    chk({tag, ".starts"},      32'(starts),            32'(nbytes));
    chk({tag, ".dones"},       32'(dones),             32'd1);
    chk({tag, ".writes"},      32'(nwr),               32'(nbytes));
    chk({tag, ".wr_addr_bad"}, 32'(nbad),              32'd0);
    chk({tag, ".first_start"}, 32'(first_start),       32'(GUARD ? 3 : 2));
    chk({tag, ".done_lat"},    32'(done_cyc - last_wr), 32'(GUARD ? 2 : 1));
    chk({tag, ".cs_busy_bad"}, 32'(cs_bad),            32'd0);
    chk({tag, ".sel_bad"},     32'(sel_bad),           32'd0);
    chk({tag, ".n_tx"},        32'(n_tx),              32'(10'(nbytes)));
    if (chk3) begin
      chk({tag, ".w3_starts"}, 32'(starts3), 32'(nbytes));
      chk({tag, ".w3_writes"}, 32'(nwr3),    32'(nbytes));
      chk({tag, ".w3_dones"},  32'(dones3),  32'd1);
      chk({tag, ".w3_bad"},    32'(bad3),    32'd0);
      // Eight completed bytes do not fit a 3-bit count, so it reads back modulo 8.
      chk({tag, ".w3_n_tx"},   32'(n_tx3),   32'(nbytes % 8));
    end
    @(posedge clk); #1;
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_cs_n"}, 32'(cs_n), 32'd1);
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int pend;
    bit found;
    rst = 1'b1; send = 1'b0; all_ones = 1'b0; all_zeros = 1'b0; spi_done = 1'b0; n_tx_end = 10'd0;
    @(posedge clk); #1;
    chk_outs("reset", 1'b0, 2'b00, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    rst = 1'b0;

    // Two-byte all-zeros transaction with ignored stimulus, DONE-ignored send, then held-send single all-ones byte.
    add(0,0,0,10'd0,0, 0,2'b00,10'd0,0,1,0,0,10'd0);
    add(1,0,1,10'd1,0, 0,2'b10,10'd0,0,0,1,0,10'd0);
    if (GUARD != 0) add(0,0,0,10'd0,0, 0,2'b10,10'd0,0,0,1,0,10'd0);
    add(0,1,0,10'd3,1, 1,2'b10,10'd0,0,0,1,0,10'd0);
    add(0,0,0,10'd0,0, 0,2'b10,10'd0,0,0,1,0,10'd0);
    add(1,0,0,10'd0,0, 0,2'b10,10'd0,0,0,1,0,10'd0);
    add(0,0,0,10'd0,1, 0,2'b10,10'd0,1,0,1,0,10'd0);
    add(0,0,0,10'd0,0, 0,2'b10,10'd1,0,0,1,0,10'd1);
    add(0,0,0,10'd0,0, 1,2'b10,10'd1,0,0,1,0,10'd1);
    add(0,0,0,10'd0,0, 0,2'b10,10'd1,0,0,1,0,10'd1);
    add(0,0,0,10'd0,1, 0,2'b10,10'd1,1,0,1,0,10'd1);
    if (GUARD != 0) add(0,0,0,10'd0,0, 0,2'b10,10'd1,0,0,1,0,10'd2);
    add(0,0,0,10'd0,0, 0,2'b10,10'd1,0,1,0,1,10'd2);
    add(1,1,1,10'd0,0, 0,2'b10,10'd1,0,1,0,0,10'd2);
    add(1,1,1,10'd0,0, 0,2'b01,10'd0,0,0,1,0,10'd0);
    if (GUARD != 0) add(0,0,0,10'd0,0, 0,2'b01,10'd0,0,0,1,0,10'd0);
    add(0,0,0,10'd0,0, 1,2'b01,10'd0,0,0,1,0,10'd0);
    add(0,0,0,10'd0,0, 0,2'b01,10'd0,0,0,1,0,10'd0);
    add(0,0,0,10'd0,1, 0,2'b01,10'd0,1,0,1,0,10'd0);
    if (GUARD != 0) add(0,0,0,10'd0,0, 0,2'b01,10'd0,0,0,1,0,10'd1);
    add(0,0,0,10'd0,0, 0,2'b01,10'd0,0,1,0,1,10'd1);
    add(0,0,0,10'd0,0, 0,2'b01,10'd0,0,1,0,0,10'd1);

    for (int i = 0; i < vq.size(); i++) begin
      send = vq[i].send; all_ones = vq[i].ones; all_zeros = vq[i].zeros;
      n_tx_end = vq[i].endv; spi_done = vq[i].sdone;
      @(posedge clk); #1;
      chk_outs($sformatf("vec%0d", i), vq[i].start, vq[i].sel, vq[i].addr, vq[i].wr,
               vq[i].csn, vq[i].busy, vq[i].done, vq[i].ntx);
    end
    send = 1'b0; spi_done = 1'b0; all_ones = 1'b0; all_zeros = 1'b0;

    run_txn("three",  10'd2, 1'b0, 1'b0, 3, 1'b0);
    run_txn("ones",   10'd5, 1'b1, 1'b0, 1, 1'b0);
    run_txn("zeros",  10'd0, 1'b0, 1'b1, 2, 1'b0);
    run_txn("w3full", 10'd7, 1'b0, 1'b0, 2, 1'b1);

    // Reset in WAIT of byte 1 must drop chip select and clear the count without a clock edge.
    send = 1'b1; n_tx_end = 10'd3;
    @(posedge clk); #1;
    send = 1'b0;
    found = 1'b0; pend = -1;
    for (int c = 0; c < 60; c++) begin
      if (spi_start) begin
        if (addr == 10'd1) begin
          found = 1'b1;
          break;
        end
        pend = c + 2;
      end
      spi_done = (c == pend);
      @(posedge clk); #1;
    end
    spi_done = 1'b0;
    chk("rst.reach_byte1", 32'(found), 32'd1);
    @(posedge clk); #1;
    chk("rst.pre_busy", 32'(busy), 32'd1);
    chk("rst.pre_n_tx", 32'(n_tx), 32'd1);
    #2 rst = 1'b1;
    #1 chk_outs("rst.async", 1'b0, 2'b00, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn("post_rst", 10'd1, 1'b0, 1'b0, 2, 1'b0);

    run_txn("full", 10'd1023, 1'b0, 1'b0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
